// File: rtl/crosswalk_pkg.sv
// Shared types and constants for the crosswalk controller and its request front end.
package crosswalk_pkg;

  localparam int DEB_CYCLES_DEF = 1000;
  localparam int DEB_W_DEF      = 10;
  localparam int WAIT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2,
    ST_REL   = 2'd3
  } req_state_e;

  // One-hot lamp encoding: pedestrian red/green, road red/green/yellow
  localparam logic [4:0] LIGHT_PR = 5'b00001;
  localparam logic [4:0] LIGHT_PG = 5'b00010;
  localparam logic [4:0] LIGHT_RR = 5'b00100;
  localparam logic [4:0] LIGHT_RG = 5'b01000;
  localparam logic [4:0] LIGHT_RY = 5'b10000;

  function automatic logic rose(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/crosswalk_debounce.sv
// Two-flop synchroniser plus counter debouncer for one asynchronous input.
// The stable level moves only after DEB_CYCLES consecutive cycles of disagreement.
module crosswalk_debounce
  import crosswalk_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [DEB_W-1:0] r_cnt;
  logic [DEB_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    if (r_sync2 == r_level) begin
      w_cnt_nxt = {DEB_W{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      // Disagreement has now lasted DEB_CYCLES samples: accept the new level
      w_level_nxt = r_sync2;
      w_cnt_nxt   = {DEB_W{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + DEB_W'(1'b1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= {DEB_W{1'b0}};
      r_level <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/crosswalk_request_frontend.sv
// Pedestrian request front end: debounces button and sensor, latches a request
// until the controller shows pedestrian green, and reports wait time and service.
module crosswalk_request_frontend
  import crosswalk_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF,
  parameter int WAIT_W     = WAIT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_btn_raw,
  input  logic              i_sen_raw,
  input  logic              i_pg,
  output logic              o_button,
  output logic              o_sensor,
  output logic [WAIT_W-1:0] o_wait_cnt,
  output logic              o_served
);

  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};

  logic              w_btn_level;
  logic              w_sen_level;
  logic              w_press;
  logic [WAIT_W-1:0] w_wait_inc;

  req_state_e        r_state;
  req_state_e        w_state_nxt;
  logic              r_btn_prev;
  logic              r_sensor;
  logic              r_button;
  logic              r_served;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_button_nxt;
  logic              w_served_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;

  crosswalk_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_btn_deb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_btn_raw),
    .o_level (w_btn_level)
  );

  crosswalk_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_sen_deb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_sen_raw),
    .o_level (w_sen_level)
  );

  assign w_press    = rose(w_btn_level, r_btn_prev);
  assign w_wait_inc = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1'b1);

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_served_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wait_nxt = WAIT_ZERO;
        // A press while green is already showing is dropped, not queued
        if (w_press && !i_pg) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_wait_nxt = w_wait_inc;
        if (i_pg) begin
          w_state_nxt  = ST_SERVE;
          w_served_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_SERVE: begin
        if (!i_pg) begin
          w_state_nxt = ST_REL;
        end else begin
          w_state_nxt = ST_SERVE;
        end
      end
      ST_REL: begin
        // Wait for release so a button held through green cannot re-request
        if (!w_btn_level) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = WAIT_ZERO;
        end else begin
          w_state_nxt = ST_REL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = WAIT_ZERO;
      end
    endcase
    w_button_nxt = (w_state_nxt == ST_REQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_btn_prev <= 1'b0;
      r_sensor   <= 1'b0;
      r_button   <= 1'b0;
      r_served   <= 1'b0;
      r_wait_cnt <= WAIT_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_btn_prev <= w_btn_level;
      r_sensor   <= w_sen_level;
      r_button   <= w_button_nxt;
      r_served   <= w_served_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  assign o_button   = r_button;
  assign o_sensor   = r_sensor;
  assign o_wait_cnt = r_wait_cnt;
  assign o_served   = r_served;

endmodule

// File: tb/tb_crosswalk_request_frontend.sv
// Bench for crosswalk_request_frontend: directed vector table, hand sequences
// for latency/saturation/async reset, and random stimulus against a reference model.
module tb_crosswalk_request_frontend;

  localparam int DEB  = 4;
  localparam int DEBW = 3;
  localparam int NVEC = 22;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic sen_raw;
  logic pg;

  logic        button_a, sensor_a, served_a;
  logic [15:0] wait_a;
  logic        button_b, sensor_b, served_b;
  logic [3:0]  wait_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (index 0 = button, 1 = sensor)
  int m_s1[2];
  int m_s2[2];
  int m_stable[2];
  int m_run[2];
  int m_btn_prev, m_sensor;
  int m_pending, m_green, m_rel, m_wait, m_served;

  int btn_hold, sen_hold, pg_hold;

  typedef struct {
    logic btn;
    logic sen;
    logic pg;
    int   n;
    logic e_button;
    logic e_sensor;
    logic e_served;
    int   e_wait;
  } vec_t;

  vec_t vecs [NVEC];

  always #10 clk = ~clk;

  crosswalk_request_frontend #(.DEB_CYCLES(DEB), .DEB_W(DEBW), .WAIT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(btn_raw), .i_sen_raw(sen_raw), .i_pg(pg),
    .o_button(button_a), .o_sensor(sensor_a), .o_wait_cnt(wait_a), .o_served(served_a)
  );

  crosswalk_request_frontend #(.DEB_CYCLES(DEB), .DEB_W(DEBW), .WAIT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(btn_raw), .i_sen_raw(sen_raw), .i_pg(pg),
    .o_button(button_b), .o_sensor(sensor_b), .o_wait_cnt(wait_b), .o_served(served_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_run[i] = 0;
    end
    m_btn_prev = 0; m_sensor = 0;
    m_pending = 0; m_green = 0; m_rel = 0; m_wait = 0; m_served = 0;
  endtask

  // One clock edge of the specification's behaviour, all from pre-edge values
  task automatic model_edge();
    int raw[2];
    int old_btn, old_sen, press;
    raw[0]  = int'(btn_raw);
    raw[1]  = int'(sen_raw);
    old_btn = m_stable[0];
    old_sen = m_stable[1];
    press   = (old_btn == 1 && m_btn_prev == 0) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] == m_stable[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_stable[i] = m_s2[i];
          m_run[i]    = 0;
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    m_btn_prev = old_btn;
    m_sensor   = old_sen;
    m_served   = 0;
    if (m_pending == 1) begin
      m_wait++;
      if (pg) begin m_pending = 0; m_green = 1; m_served = 1; end
    end else if (m_green == 1) begin
      if (!pg) begin m_green = 0; m_rel = 1; end
    end else if (m_rel == 1) begin
      if (old_btn == 0) begin m_rel = 0; m_wait = 0; end
    end else begin
      m_wait = 0;
      if (press == 1 && !pg) m_pending = 1;
    end
  endtask

  task automatic check_model();
    chk("model button", int'(button_a), m_pending);
    chk("model sensor", int'(sensor_a), m_sensor);
    chk("model served", int'(served_a), m_served);
    chk("model wait16", int'(wait_a), (m_wait > 65535) ? 65535 : m_wait);
    chk("model wait4",  int'(wait_b), (m_wait > 15) ? 15 : m_wait);
    chk("model button4", int'(button_b), m_pending);
    chk("model served4", int'(served_b), m_served);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_clear();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " button"}, int'(button_a | button_b), 0);
    chk({name, " sensor"}, int'(sensor_a | sensor_b), 0);
    chk({name, " served"}, int'(served_a | served_b), 0);
    chk({name, " wait"}, int'(wait_a) + int'(wait_b), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0,  5, 1'b0, 1'b0, 1'b0,  0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0,  0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0,  0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b0,  0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0,  0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0, 24};
    vecs[6]  = '{1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b1, 25};
    vecs[7]  = '{1'b0, 1'b1, 1'b1,  3, 1'b0, 1'b1, 1'b0, 25};
    vecs[8]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 25};
    vecs[9]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0,  0};
    vecs[10] = '{1'b0, 1'b0, 1'b0,  7, 1'b0, 1'b0, 1'b0,  0};
    vecs[11] = '{1'b1, 1'b0, 1'b0,  7, 1'b1, 1'b0, 1'b0,  0};
    vecs[12] = '{1'b1, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0,  1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0,  1};
    vecs[14] = '{1'b0, 1'b0, 1'b0,  8, 1'b0, 1'b0, 1'b0,  0};
    vecs[15] = '{1'b1, 1'b0, 1'b0,  7, 1'b1, 1'b0, 1'b0,  0};
    vecs[16] = '{1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1,  1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0,  1};
    vecs[18] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0,  0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b0,  0};
    vecs[20] = '{1'b1, 1'b0, 1'b0,  5, 1'b0, 1'b0, 1'b0,  0};
    vecs[21] = '{1'b0, 1'b0, 1'b0,  8, 1'b0, 1'b0, 1'b0,  0};

    model_clear();
    rst_n = 1'b0; btn_raw = 1'b1; sen_raw = 1'b0; pg = 1'b0;

    // Reset held with the button pressed
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all_zero($sformatf("reset cycle%0d", k));
    end
    rst_n = 1'b1; btn_raw = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk_all_zero("after reset");

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      btn_raw = vecs[i].btn; sen_raw = vecs[i].sen; pg = vecs[i].pg;
      for (int k = 0; k < vecs[i].n; k++) step();
      chk($sformatf("vec%0d button", i), int'(button_a), int'(vecs[i].e_button));
      chk($sformatf("vec%0d sensor", i), int'(sensor_a), int'(vecs[i].e_sensor));
      chk($sformatf("vec%0d served", i), int'(served_a), int'(vecs[i].e_served));
      chk($sformatf("vec%0d wait16", i), int'(wait_a), vecs[i].e_wait);
      chk($sformatf("vec%0d wait4", i), int'(wait_b), (vecs[i].e_wait > 15) ? 15 : vecs[i].e_wait);
    end

    // Exact press latency: BUTTON rises on the 7th edge after the raw edge
    btn_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("latency edge%0d", k), int'(button_a), (k == 7) ? 1 : 0);
    end

    // Long wait: 4-bit counter saturates, 16-bit keeps counting
    btn_raw = 1'b0;
    for (int k = 0; k < 40; k++) step();
    chk("sat wait16", int'(wait_a), 40);
    chk("sat wait4", int'(wait_b), 15);
    chk("sat button", int'(button_a & button_b), 1);

    // Asynchronous reset in the middle of a request, away from any edge
    #4;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_all_zero("async reset");
    step();
    step();
    #8;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Single-cycle served pulse coincident with BUTTON falling
    btn_raw = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("pulse pre button", int'(button_a), 1);
    pg = 1'b1;
    step();
    chk("pulse served", int'(served_a), 1);
    chk("pulse button fall", int'(button_a), 0);
    step();
    chk("pulse served drop", int'(served_a), 0);
    pg = 1'b0; btn_raw = 1'b0;
    for (int k = 0; k < 10; k++) step();

    // Random bouncy inputs against the model
    btn_hold = 0; sen_hold = 0; pg_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (btn_hold == 0) begin
        btn_raw  = ~btn_raw;
        btn_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
      end else begin
        btn_hold--;
      end
      if (sen_hold == 0) begin
        sen_raw  = ~sen_raw;
        sen_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
      end else begin
        sen_hold--;
      end
      if (pg_hold == 0) begin
        pg      = ~pg;
        pg_hold = int'($urandom_range(3, 80));
      end else begin
        pg_hold--;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crosswalk_request_frontend.md
Name: crosswalk_request_frontend

Overview:
- Producer side of the crosswalk controller's BUTTON/SENSOR inputs.
- Synchronises and debounces the raw pedestrian push-button and vehicle sensor, then latches a pedestrian request on BUTTON.
- Holds the request until the controller acknowledges it by driving PG high.
- Feeds back a wait-time counter and a served pulse for status LEDs and debug.

Parameters:
- DEB_CYCLES, 1000: consecutive stable cycles needed before a debounced level changes. At 50 MHz this is 20 us; must be >= 2.
- DEB_W, 10: width of the debounce counters. Must satisfy 2^DEB_W > DEB_CYCLES.
- WAIT_W, 16: width of WAIT_CNT.

Ports:
- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous reset, active-low (0 = reset)
- BTN_RAW  in  1  raw push-button, asynchronous, bouncy, 1 = pressed
- SEN_RAW  in  1  raw vehicle sensor, asynchronous, 1 = vehicle present
- PG  in  1  pedestrian green from the crosswalk controller, CLK domain
- BUTTON  out  1  latched pedestrian request to the controller
- SENSOR  out  1  debounced vehicle-present level to the controller
- WAIT_CNT  out  WAIT_W  cycles spent in REQ, saturating
- SERVED  out  1  one-cycle pulse when a request is acknowledged

Behaviour:
- Reset (RST=0, asynchronous):
  - all flops cleared; FSM in IDLE
  - BUTTON=0, SENSOR=0, WAIT_CNT=0, SERVED=0
  - debounced levels = 0; debounce counters = 0
  - reset mid-request drops the request with no pulse.
- Synchroniser: 2-FF chain on BTN_RAW and SEN_RAW. PG is used unsynchronised because it is already in the CLK domain.
- Debouncer (one per input, identical):
  - Per cycle, if the synced input equals the stable level, the counter resets to 0.
  - Otherwise the counter increments. When the counter reaches DEB_CYCLES-1 and the input still differs, the stable level takes the input value and the counter resets to 0.
  - Any glitch shorter than DEB_CYCLES cycles never reaches the stable level.
- Latency: a clean raw edge held steady reaches the stable level DEB_CYCLES+2 edges after the first edge that samples it.
- SENSOR is a registered copy of the stable sensor level (total DEB_CYCLES+3 edges).
- Press event: rising edge of the stable button level (previous-cycle register).
- FSM (registered outputs):
  - IDLE: BUTTON=0, WAIT_CNT=0.
    - Press event with PG=0 -> REQ.
    - Press event with PG=1 -> stays IDLE; the press is discarded because the pedestrian is already being served.
  - REQ: BUTTON=1, WAIT_CNT increments by 1 per cycle and saturates at 2^WAIT_W-1.
    - PG=1 -> SERVE; SERVED=1 for exactly that one cycle.
    - Further press events are ignored.
  - SERVE: BUTTON=0; WAIT_CNT holds its last value.
    - PG=0 -> REL.
    - Presses are ignored.
  - REL: BUTTON=0; WAIT_CNT holds.
    - Stable button level = 0 -> IDLE, and WAIT_CNT clears on entry to IDLE.
    - Otherwise stays in REL. A button held through a whole green must be released before it can raise a new request.
- BUTTON timing:
  - BUTTON rises one edge after the press event, i.e. DEB_CYCLES+3 edges after the raw edge.
  - BUTTON falls on the same edge SERVED rises.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Shared package crosswalk_pkg:
  - FSM state enum (IDLE, REQ, SERVE, REL)
  - default DEB_CYCLES constant
  - shared light-encoding constants for PR/PG/RR/RG/RY
- One sub-module, crosswalk_debounce, parameterised on DEB_CYCLES/DEB_W. It contains the 2-FF synchroniser, the counter and the stable level, and is instantiated twice (button, sensor).
- The FSM and counter live in the top.

Test Plan (DEB_CYCLES=4, CLK period 20 ns):
- Reset: RST=0 for 3 cycles with BTN_RAW=1 -> BUTTON=0, SENSOR=0, WAIT_CNT=0, SERVED=0 throughout; FSM IDLE after RST=1.
- Glitch rejection: BTN_RAW high for 3 cycles then low -> BUTTON never rises. Held 10 cycles -> BUTTON=1 exactly 7 edges after the first sampling edge.
- Handshake: press, then PG=1 after 25 cycles in REQ -> SERVED pulses once; BUTTON falls on the same edge; WAIT_CNT=25 and held. PG=0 with button released -> IDLE, WAIT_CNT=0.
- Held button: BTN_RAW stays high through PG 1->0 -> FSM stays REL and BUTTON stays 0. Release then press again -> new request, BUTTON=1.
- Press during green: PG=1 while in IDLE and a clean press occurs -> BUTTON stays 0, no SERVED.
- Saturation/reset: WAIT_W=4, stay in REQ 40 cycles -> WAIT_CNT=15. RST=0 mid-REQ -> BUTTON=0 and WAIT_CNT=0 immediately (asynchronous).
